// File: rtl/uart_rx_sampler.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_sampler
// Purpose  : UART receive front end. Synchronises the asynchronous serial
//            line, qualifies start bits against an oversampling baud tick,
//            samples each bit at mid-bit and emits one-clock strobes for the
//            downstream receive datapath. Flags framing errors and breaks.
// Ports    : clock        - system clock, rising edge
//            reset        - synchronous, active-low reset
//            baud_tick    - one-clock enable, OVERSAMPLE times per bit
//            rx_serial    - raw asynchronous serial line (idles high)
//            data_in      - last sampled data bit (valid with data_shift)
//            data_shift   - one-clock pulse per sampled data bit
//            bit_index    - data bits sampled in the current frame
//            start_bit    - idles 1, low for one clock on start confirmation
//            parity       - last sampled parity bit (held)
//            parity_valid - one-clock pulse when parity is updated
//            stop_bit     - one-clock pulse on a valid (high) stop bit
//            framing_err  - one-clock pulse when the stop bit is low
//            busy         - high in every state except IDLE
// Options  : UART_RX_MAJORITY_VOTE_EN - when defined, each decision uses a
//            majority of the live sample and the two previous tick samples.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_sampler #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_BIT = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       baud_tick,
    input  logic       rx_serial,
    output logic       data_in,
    output logic       data_shift,
    output logic [3:0] bit_index,
    output logic       start_bit,
    output logic       parity,
    output logic       parity_valid,
    output logic       stop_bit,
    output logic       framing_err,
    output logic       busy
);

    localparam int                 c_CNT_W     = $clog2(OVERSAMPLE);
    localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_FULL_LAST = c_CNT_W'(OVERSAMPLE - 1);
    localparam logic [3:0]         c_LAST_BIT  = 4'(DATA_BITS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    state_t               r_state_q, w_state_d;
    logic [1:0]           r_sync_q, w_sync_d;
    logic [c_CNT_W-1:0]   r_cnt_q, w_cnt_d;
    logic [3:0]           r_bit_index_q, w_bit_index_d;
    logic                 r_data_in_q, w_data_in_d;
    logic                 r_data_shift_q, w_data_shift_d;
    logic                 r_start_bit_q, w_start_bit_d;
    logic                 r_parity_q, w_parity_d;
    logic                 r_parity_valid_q, w_parity_valid_d;
    logic                 r_stop_bit_q, w_stop_bit_d;
    logic                 r_framing_err_q, w_framing_err_d;
    logic                 r_busy_q, w_busy_d;
    logic                 w_rx_s;
    logic                 w_v;

    // Two-flop synchroniser; everything downstream looks only at w_rx_s.
    assign w_sync_d = {r_sync_q[0], rx_serial};
    assign w_rx_s   = r_sync_q[1];

`ifdef UART_RX_MAJORITY_VOTE_EN
    // Three-sample window: two history bits captured on earlier ticks plus
    // the live sample on the decision tick. History is primed high on START
    // entry so a stale low from a previous frame cannot bias the vote.
    logic [1:0] r_vote_q, w_vote_d;

    always_comb begin
        w_vote_d = r_vote_q;
        if (baud_tick) begin
            if (r_state_q == S_IDLE && !w_rx_s) begin
                w_vote_d = 2'b11;
            end else begin
                w_vote_d = {r_vote_q[0], w_rx_s};
            end
        end
    end

    assign w_v = (r_vote_q[1] & r_vote_q[0]) | (r_vote_q[1] & w_rx_s) |
                 (r_vote_q[0] & w_rx_s);

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_vote_q <= 2'b11;
        end else begin
            r_vote_q <= w_vote_d;
        end
    end
`else
    assign w_v = w_rx_s;
`endif

    always_comb begin
        w_state_d        = r_state_q;
        w_cnt_d          = r_cnt_q;
        w_bit_index_d    = r_bit_index_q;
        w_data_in_d      = r_data_in_q;
        w_parity_d       = r_parity_q;
        w_data_shift_d   = 1'b0;
        w_start_bit_d    = 1'b1;
        w_parity_valid_d = 1'b0;
        w_stop_bit_d     = 1'b0;
        w_framing_err_d  = 1'b0;

        case (r_state_q)
            S_IDLE: begin
                if (baud_tick && !w_rx_s) begin
                    w_state_d = S_START;
                    w_cnt_d   = '0;
                end
            end
            S_START: begin
                if (baud_tick) begin
                    if (r_cnt_q == c_HALF_LAST) begin
                        if (!w_v) begin
                            w_start_bit_d = 1'b0;
                            w_cnt_d       = '0;
                            w_bit_index_d = 4'd0;
                            w_state_d     = S_DATA;
                        end else begin
                            // Too short to be a start bit: treat as a glitch.
                            w_state_d = S_IDLE;
                        end
                    end else begin
                        w_cnt_d = r_cnt_q + 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (baud_tick) begin
                    if (r_cnt_q == c_FULL_LAST) begin
                        w_data_in_d    = w_v;
                        w_data_shift_d = 1'b1;
                        w_bit_index_d  = r_bit_index_q + 4'd1;
                        w_cnt_d        = '0;
                        if (r_bit_index_q + 4'd1 == c_LAST_BIT) begin
                            w_state_d = (PARITY_BIT != 0) ? S_PARITY : S_STOP;
                        end
                    end else begin
                        w_cnt_d = r_cnt_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (baud_tick) begin
                    if (r_cnt_q == c_FULL_LAST) begin
                        w_parity_d       = w_v;
                        w_parity_valid_d = 1'b1;
                        w_cnt_d          = '0;
                        w_state_d        = S_STOP;
                    end else begin
                        w_cnt_d = r_cnt_q + 1'b1;
                    end
                end
            end
            S_STOP: begin
                if (baud_tick) begin
                    if (r_cnt_q == c_FULL_LAST) begin
                        w_cnt_d = '0;
                        if (w_v) begin
                            w_stop_bit_d = 1'b1;
                            w_state_d    = S_IDLE;
                        end else begin
                            w_framing_err_d = 1'b1;
                            w_state_d       = S_BREAK;
                        end
                    end else begin
                        w_cnt_d = r_cnt_q + 1'b1;
                    end
                end
            end
            S_BREAK: begin
                // Wait for the line to recover; a held-low line never starts
                // a new frame.
                if (w_rx_s) begin
                    w_state_d = S_IDLE;
                end
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase

        // Registered from the next state so busy lines up with the state.
        w_busy_d = (w_state_d != S_IDLE);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state_q        <= S_IDLE;
            r_sync_q         <= 2'b11;
            r_cnt_q          <= '0;
            r_bit_index_q    <= 4'd0;
            r_data_in_q      <= 1'b0;
            r_data_shift_q   <= 1'b0;
            r_start_bit_q    <= 1'b1;
            r_parity_q       <= 1'b0;
            r_parity_valid_q <= 1'b0;
            r_stop_bit_q     <= 1'b0;
            r_framing_err_q  <= 1'b0;
            r_busy_q         <= 1'b0;
        end else begin
            r_state_q        <= w_state_d;
            r_sync_q         <= w_sync_d;
            r_cnt_q          <= w_cnt_d;
            r_bit_index_q    <= w_bit_index_d;
            r_data_in_q      <= w_data_in_d;
            r_data_shift_q   <= w_data_shift_d;
            r_start_bit_q    <= w_start_bit_d;
            r_parity_q       <= w_parity_d;
            r_parity_valid_q <= w_parity_valid_d;
            r_stop_bit_q     <= w_stop_bit_d;
            r_framing_err_q  <= w_framing_err_d;
            r_busy_q         <= w_busy_d;
        end
    end

    assign data_in      = r_data_in_q;
    assign data_shift   = r_data_shift_q;
    assign bit_index    = r_bit_index_q;
    assign start_bit    = r_start_bit_q;
    assign parity       = r_parity_q;
    assign parity_valid = r_parity_valid_q;
    assign stop_bit     = r_stop_bit_q;
    assign framing_err  = r_framing_err_q;
    assign busy         = r_busy_q;

endmodule
`default_nettype wire
